// File: rtl/banked_spram_array.sv
// Banked single-port-style RAM array: NUM_BANKS independent DEPTH x DWIDTH banks
// with read/write ports selected by id, and a clear engine that zeroes every bank.
module banked_spram_array #(
   parameter int DWIDTH    = 9,
   parameter int DEPTH     = 4096,
   parameter int AWIDTH    = $clog2(DEPTH),
   parameter int NUM_BANKS = 2,
   parameter int IDW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   parameter int OUT_REG   = 0,
   parameter int RDW_MODE  = 0
) (
   input  logic              clock0,
   input  logic              rst_n,
   input  logic              rce,
   input  logic [AWIDTH-1:0] ra,
   input  logic              wce,
   input  logic [AWIDTH-1:0] wa,
   input  logic [DWIDTH-1:0] wd,
   input  logic [IDW-1:0]    id,
   input  logic              clr,
   output logic [DWIDTH-1:0] rq,
   output logic              rq_valid,
   output logic              busy
);

   // state    | meaning
   // ST_CLEAR | zeroing address cnt in every bank, accesses ignored
   // ST_RUN   | normal read/write service
   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_RUN   = 1'b1;

   localparam logic [IDW:0] NB = NUM_BANKS[IDW:0];

   logic              state;
   logic [AWIDTH-1:0] cnt;
   logic [DWIDTH-1:0] mem [NUM_BANKS][DEPTH];

   logic              run;
   logic              id_ok;
   logic [IDW-1:0]    bank;
   logic              do_wr;
   logic              do_rd;

   logic              v1;
   logic              v2;
   logic [DWIDTH-1:0] d1;
   logic [DWIDTH-1:0] d2;

   assign run   = (state == ST_RUN);
   assign busy  = ~run;
   assign id_ok = ({1'b0, id} < NB);
   assign bank  = id_ok ? id : '0;
   assign do_wr = run & wce & id_ok;
   assign do_rd = run & rce;

   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               cnt <= cnt + AWIDTH'(1);
               if (cnt == AWIDTH'(DEPTH - 1)) state <= ST_RUN;
            end
            ST_RUN: begin
               if (clr) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // Clear writes the same address in all banks at once.
   always_ff @(posedge clock0) begin
      if (!run) begin
         for (int b = 0; b < NUM_BANKS; b++) mem[b][cnt] <= '0;
      end else if (do_wr) begin
         mem[bank][wa] <= wd;
      end
   end

   // Bank choice is resolved at issue, so later id changes cannot alter in-flight data.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         d1 <= '0;
         v2 <= 1'b0;
         d2 <= '0;
      end else begin
         v1 <= do_rd;
         if (do_rd) begin
            if (!id_ok)
               d1 <= '0;
            else if ((RDW_MODE != 0) && do_wr && (wa == ra))
               d1 <= wd;
            else
               d1 <= mem[bank][ra];
         end
         v2 <= v1;
         if (v1) d2 <= d1;
      end
   end

   assign rq       = (OUT_REG != 0) ? d2 : d1;
   assign rq_valid = (OUT_REG != 0) ? v2 : v1;

endmodule

// File: tb/tb_banked_spram_array.sv
// Two configurations driven in lockstep: (2 banks, no out reg, read-first) and
// (3 banks, out reg, write-first), each compared every cycle to a behavioural model.
module tb_banked_spram_array;

   localparam int DW  = 9;
   localparam int DEP = 4096;
   localparam int AW  = 12;

   logic          clock0 = 1'b0;
   logic          rst_n  = 1'b0;
   logic          rce    = 1'b0;
   logic          wce    = 1'b0;
   logic          clr    = 1'b0;
   logic [AW-1:0] ra     = '0;
   logic [AW-1:0] wa     = '0;
   logic [DW-1:0] wd     = '0;
   logic [1:0]    id     = '0;

   logic [DW-1:0] rq_a, rq_b;
   logic          rqv_a, rqv_b, busy_a, busy_b;

   always #5 clock0 = ~clock0;

   banked_spram_array #(.DWIDTH(DW), .DEPTH(DEP), .NUM_BANKS(2), .OUT_REG(0), .RDW_MODE(0)) dut_a (
      .clock0(clock0), .rst_n(rst_n), .rce(rce), .ra(ra), .wce(wce), .wa(wa), .wd(wd),
      .id(id[0:0]), .clr(clr), .rq(rq_a), .rq_valid(rqv_a), .busy(busy_a));

   banked_spram_array #(.DWIDTH(DW), .DEPTH(DEP), .NUM_BANKS(3), .OUT_REG(1), .RDW_MODE(1)) dut_b (
      .clock0(clock0), .rst_n(rst_n), .rce(rce), .ra(ra), .wce(wce), .wa(wa), .wd(wd),
      .id(id), .clr(clr), .rq(rq_b), .rq_valid(rqv_b), .busy(busy_b));

   // reference model
   logic [DW-1:0] ma [2][DEP];
   logic [DW-1:0] mb [3][DEP];
   int            clr_left;
   logic          ea_v, eb_v, eb_s1v;
   logic [DW-1:0] ea_d, eb_d, eb_s1d;

   int n_total = 0;
   int n_pass  = 0;

   task automatic model_reset();
      clr_left = DEP;
      ea_v = 1'b0; ea_d = '0;
      eb_v = 1'b0; eb_d = '0;
      eb_s1v = 1'b0; eb_s1d = '0;
   endtask

   // Applies the rules to the inputs present at the clock edge just taken.
   task automatic model_edge();
      logic          rv;
      logic [DW-1:0] rda, rdb;
      int            ba;
      rv = 1'b0; rda = '0; rdb = '0;
      if (clr_left > 0) begin
         int c;
         c = DEP - clr_left;
         for (int b = 0; b < 2; b++) ma[b][c] = '0;
         for (int b = 0; b < 3; b++) mb[b][c] = '0;
         clr_left--;
      end else begin
         ba = int'(id[0]);
         if (rce) begin
            rv  = 1'b1;
            rda = ma[ba][ra];
            if (id < 2'd3) rdb = (wce && wa == ra) ? wd : mb[id][ra];
            else           rdb = '0;
         end
         if (wce) begin
            ma[ba][wa] = wd;
            if (id < 2'd3) mb[id][wa] = wd;
         end
         if (clr) clr_left = DEP;
      end
      ea_v = rv;
      if (rv) ea_d = rda;
      eb_v = eb_s1v;
      if (eb_s1v) eb_d = eb_s1d;
      eb_s1v = rv;
      if (rv) eb_s1d = rdb;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
   endtask

   task automatic check_all();
      chk("a_rq",       32'(rq_a),   32'(ea_d));
      chk("a_rq_valid", 32'(rqv_a),  32'(ea_v));
      chk("a_busy",     32'(busy_a), 32'(clr_left > 0));
      chk("b_rq",       32'(rq_b),   32'(eb_d));
      chk("b_rq_valid", 32'(rqv_b),  32'(eb_v));
      chk("b_busy",     32'(busy_b), 32'(clr_left > 0));
   endtask

   task automatic step(input logic i_rce, input logic [AW-1:0] i_ra, input logic i_wce,
                       input logic [AW-1:0] i_wa, input logic [DW-1:0] i_wd,
                       input logic [1:0] i_id, input logic i_clr);
      rce = i_rce; ra = i_ra; wce = i_wce; wa = i_wa; wd = i_wd; id = i_id; clr = i_clr;
      @(posedge clock0);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, ra, 1'b0, wa, wd, id, 1'b0);
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      for (int i = 0; i < DEP + 16 && busy_a; i++) begin
         idle(1);
         cyc++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [AW-1:0] a_r, a_w;

      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock0);
      #1;
      check_all();
      rst_n = 1'b1;
      wait_ready(cyc);
      chk("clear_len_init", 32'(cyc), 32'(DEP));

      // freshly cleared contents
      step(1'b1, 12'h000, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'hFFF, 1'b0, 12'h000, 9'h000, 2'd1, 1'b0);
      idle(2);

      // bank isolation
      step(1'b0, 12'h000, 1'b1, 12'h123, 9'h1A5, 2'd0, 1'b0);
      step(1'b0, 12'h000, 1'b1, 12'h123, 9'h0F0, 2'd1, 1'b0);
      step(1'b1, 12'h123, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h123, 1'b0, 12'h000, 9'h000, 2'd1, 1'b0);
      idle(2);

      // read-during-write
      step(1'b0, 12'h000, 1'b1, 12'h010, 9'h055, 2'd0, 1'b0);
      step(1'b1, 12'h010, 1'b1, 12'h010, 9'h0AA, 2'd0, 1'b0);
      step(1'b1, 12'h010, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      idle(2);

      // back-to-back reads, id toggled after issue
      step(1'b0, 12'h000, 1'b1, 12'h001, 9'h101, 2'd0, 1'b0);
      step(1'b0, 12'h000, 1'b1, 12'h002, 9'h102, 2'd0, 1'b0);
      step(1'b0, 12'h000, 1'b1, 12'h003, 9'h103, 2'd0, 1'b0);
      step(1'b1, 12'h001, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h002, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h003, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b0, 12'h000, 1'b0, 12'h000, 9'h000, 2'd1, 1'b0);
      step(1'b0, 12'h000, 1'b0, 12'h000, 9'h000, 2'd2, 1'b0);
      idle(2);

      // out-of-range id for the 3-bank config
      step(1'b0, 12'h000, 1'b1, 12'h123, 9'h077, 2'd3, 1'b0);
      step(1'b1, 12'h123, 1'b0, 12'h000, 9'h000, 2'd3, 1'b0);
      for (int b = 0; b < 3; b++) step(1'b1, 12'h123, 1'b0, 12'h000, 9'h000, 2'(b), 1'b0);
      idle(3);

      // randomized traffic on a small address pool plus corners
      for (int i = 0; i < 1500; i++) begin
         a_r = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         a_w = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         step(1'($urandom_range(0, 1)), a_r, 1'($urandom_range(0, 1)), a_w,
              DW'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      end
      idle(3);

      // clear request with a same-cycle write and read, re-request ignored mid-clear
      step(1'b1, 12'h001, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h002, 1'b1, 12'h800, 9'h1FF, 2'd0, 1'b1);
      idle(100);
      step(1'b1, 12'h003, 1'b1, 12'h004, 9'h0EE, 2'd0, 1'b1);
      wait_ready(cyc);
      chk("clear_len_req", 32'(cyc), 32'(DEP - 101));
      step(1'b1, 12'h800, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h001, 1'b0, 12'h000, 9'h000, 2'd1, 1'b0);
      idle(3);

      // reset halfway through a clear restarts the full sequence
      step(1'b0, 12'h000, 1'b1, 12'h005, 9'h155, 2'd0, 1'b0);
      step(1'b0, 12'h000, 1'b0, 12'h000, 9'h000, 2'd0, 1'b1);
      idle(DEP / 2);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clock0);
      #1;
      check_all();
      rst_n = 1'b1;
      wait_ready(cyc);
      chk("clear_len_after_reset", 32'(cyc), 32'(DEP));
      step(1'b1, 12'h005, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      step(1'b1, 12'h001, 1'b0, 12'h000, 9'h000, 2'd0, 1'b0);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/banked_spram_array.md
Name: banked_spram_array

Overview:
- Parametrised successor to the fixed 2-instance 9x4096 SPRAM wrapper.
- Provides NUM_BANKS independent DEPTH x DWIDTH simple-dual-address RAM banks; bank is selected by id.
- Adds selectable read-during-write mode, an optional output register and a registered bank-select for read steering.
- Adds rq_valid and an automatic/requested clear engine that zeroes all banks.
- Used as the benchmark memory block in BRAM-inference test cases.

Parameters:
DWIDTH, 9, data width per word
DEPTH, 4096, words per bank (power of two)
AWIDTH, $clog2(DEPTH), address width (derived, not overridden)
NUM_BANKS, 2, number of banks (>=1, need not be a power of two)
IDW, max(1,$clog2(NUM_BANKS)), id width (derived)
OUT_REG, 0, 1 = extra output register stage
RDW_MODE, 0, read-during-write to same bank/address: 0 READ_FIRST, 1 WRITE_FIRST

Ports:
clock0  input  1  clock, all logic rising-edge
rst_n  input  1  reset, asynchronous, active-low
rce  input  1  read enable
ra  input  AWIDTH  read address
wce  input  1  write enable
wa  input  AWIDTH  write address
wd  input  DWIDTH  write data
id  input  IDW  bank select, shared by read and write
clr  input  1  single-cycle request to re-zero all banks
rq  output  DWIDTH  read data
rq_valid  output  1  rq carries new read data this cycle
busy  output  1  clear engine active; accesses ignored

Behaviour:
- Reset (rst_n=0, async): rq=0, rq_valid=0, busy=1. Read pipeline is flushed, clear counter=0, FSM forced to CLEAR. Memory contents are undefined until CLEAR completes.
- FSM states:
  - CLEAR: each cycle writes 0 to address cnt in every bank; cnt increments. After cnt=DEPTH-1 is written, go to RUN. Duration is exactly DEPTH cycles; busy=1 throughout.
  - RUN: busy=0. clr=1 in RUN moves to CLEAR next cycle with cnt=0.
- clr asserted while already in CLEAR is ignored; the counter does not restart.
- While busy=1: rce and wce are ignored; no rq_valid is generated by new requests.
- Read issued on the cycle clr is sampled in RUN: serviced.
- Write issued on the cycle clr is sampled in RUN: performed, then overwritten by the clear.
- Reads already in flight when CLEAR starts complete normally.
- Write: wce=1 in RUN writes wd to bank[id][wa] at the clock edge. Other banks are untouched.
- Read: rce=1 in RUN samples bank[id][ra]. id is registered alongside the read so later id changes cannot corrupt the returned data.
  - OUT_REG=0: rq/rq_valid update at edge N+1 (1-cycle latency).
  - OUT_REG=1: 2-cycle latency.
  - Back-to-back reads give one result per cycle.
- rq holds its last value when no read completes; rq_valid is a 1-cycle pulse per read.
- Read-during-write (rce & wce, ra==wa, same cycle; same bank, since id is shared):
  - READ_FIRST: rq returns the old contents.
  - WRITE_FIRST: rq returns wd.
  - Different addresses proceed independently.
- Out-of-range id (id >= NUM_BANKS):
  - Write is dropped.
  - Read returns rq=0 with rq_valid asserted at normal latency.
- Reset asserted mid-read or mid-clear: pipeline discarded immediately. After release, CLEAR restarts from cnt=0.
- Address wrap: ra/wa are AWIDTH bits, so no out-of-range address is possible.

Test Plan:
- Release rst_n -> busy=1 for exactly 4096 cycles, then 0. Read bank0 addr 0x000 and bank1 addr 0xFFF -> rq=0, rq_valid 1 cycle later.
- Write 0x1A5 to bank0 addr 0x123 and 0x0F0 to bank1 addr 0x123, then read both -> rq=0x1A5 and 0x0F0 respectively; bank isolation holds.
- RDW_MODE=0: addr 0x010 holds 0x055; write 0x0AA with a same-cycle read -> rq=0x055; next read -> 0x0AA. Repeat with RDW_MODE=1 -> first read already returns 0x0AA.
- OUT_REG=1: reads of 0x001,0x002,0x003 back-to-back (preloaded 0x101,0x102,0x103) -> rq_valid high on cycles N+2..N+4 with data in order. Toggling id after issue does not change the data.
- NUM_BANKS=3: write with id=3 -> no bank changes; read with id=3 -> rq=0, rq_valid=1.
- In RUN, write 0x1FF to addr 0x800 and pulse clr -> busy for 4096 cycles; second clr mid-clear ignored. Subsequent read of 0x800 -> 0. Reset asserted halfway through clear -> busy stays 1 and clear restarts from full length.
